// File: rtl/cic_decim_mc.sv
// Multi-channel sinc^ORDER decimator for 1-bit delta-sigma bitstreams.
// Channels share one phase counter; each decimated frame is drained one word per beat.
module cic_decim_mc #(
  parameter int NCH       = 2,
  parameter int ORDER     = 3,
  parameter int RLOG2_MAX = 6,
  localparam int ACC_W    = ORDER * RLOG2_MAX + 1,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [NCH-1:0]   in_bits,
  input  logic             cfg_load,
  input  logic [2:0]       cfg_rlog2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CH_W-1:0]  out_chan,
  output logic             out_last,
  output logic             overrun,
  output logic             settling
);

  localparam int SC_W = $clog2(ORDER + 1);
  localparam logic [2:0] RMAX = 3'(RLOG2_MAX);

  typedef enum logic {IDLE, DRAIN} state_t;

  logic                              flush;
  logic [2:0]                        rlog2;
  logic [RLOG2_MAX:0]                r_val;
  logic [RLOG2_MAX-1:0]              phase_top;
  logic [RLOG2_MAX-1:0]              phase;
  logic                              tick;
  logic                              tick_d;
  logic [ORDER-1:0][ACC_W-1:0]       integ     [NCH];
  logic [ORDER-1:0][ACC_W-1:0]       comb_dly  [NCH];
  logic [ORDER:0][ACC_W-1:0]         taps      [NCH];
  logic [ACC_W-1:0]                  comb_out  [NCH];
  logic [ACC_W-1:0]                  frame_buf [NCH];
  state_t                            state;
  logic [CH_W-1:0]                   drain_ptr;
  logic [CH_W-1:0]                   next_ptr;
  logic [SC_W-1:0]                   settle_cnt;
  logic                              capture;
  logic                              emit;

  function automatic logic [2:0] clamp_rlog2(input logic [2:0] v);
    if (v == 3'd0) return 3'd1;
    if (v > RMAX) return RMAX;
    return v;
  endfunction

  // Comb chain: tap k is the input of comb stage k, tap ORDER the filter output.
  function automatic logic [ORDER:0][ACC_W-1:0] comb_taps(
    input logic [ACC_W-1:0]            top,
    input logic [ORDER-1:0][ACC_W-1:0] dly
  );
    logic [ORDER:0][ACC_W-1:0] t;
    t[0] = top;
    for (int k = 0; k < ORDER; k++) t[k+1] = t[k] - dly[k];
    return t;
  endfunction

  assign flush     = rst || cfg_load;
  assign r_val     = (RLOG2_MAX + 1)'(1) << rlog2;
  assign phase_top = RLOG2_MAX'(r_val - 1'b1);
  assign tick      = in_valid && !flush && (phase == phase_top);
  assign capture   = tick_d;
  assign emit      = capture && (settle_cnt == '0);
  assign next_ptr  = drain_ptr + 1'b1;

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) taps[ch] = comb_taps(integ[ch][ORDER-1], comb_dly[ch]);
  end

  // Integrators run at the modulator rate; combs only advance on the decimation tick.
  always_ff @(posedge clk) begin
    if (flush) begin
      rlog2  <= rst ? RMAX : clamp_rlog2(cfg_rlog2);
      phase  <= '0;
      tick_d <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        integ[ch]    <= '0;
        comb_dly[ch] <= '0;
        comb_out[ch] <= '0;
      end
    end else begin
      tick_d <= tick;
      if (in_valid) begin
        phase <= tick ? '0 : phase + 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
          integ[ch][0] <= integ[ch][0] + (in_bits[ch] ? ACC_W'(1) : {ACC_W{1'b1}});
          for (int k = 1; k < ORDER; k++) integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
        end
      end
      if (tick) begin
        for (int ch = 0; ch < NCH; ch++) begin
          for (int k = 0; k < ORDER; k++) comb_dly[ch][k] <= taps[ch][k];
          comb_out[ch] <= taps[ch][ORDER];
        end
      end
    end
  end

  // Frame capture and drain; a frame arriving mid-drain is dropped unless the
  // drain is finishing on that very cycle.
  always_ff @(posedge clk) begin
    if (flush) begin
      state      <= IDLE;
      drain_ptr  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      out_last   <= 1'b0;
      overrun    <= 1'b0;
      settling   <= 1'b1;
      settle_cnt <= SC_W'(ORDER);
      for (int ch = 0; ch < NCH; ch++) frame_buf[ch] <= '0;
    end else begin
      if (capture && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
      if (emit) settling <= 1'b0;
      case (state)
        IDLE: begin
          if (emit) begin
            frame_buf <= comb_out;
            out_data  <= comb_out[0];
            out_chan  <= '0;
            out_last  <= (NCH == 1);
            drain_ptr <= '0;
            out_valid <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (emit && !(out_ready && out_last)) overrun <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              if (emit) begin
                frame_buf <= comb_out;
                out_data  <= comb_out[0];
                out_chan  <= '0;
                out_last  <= (NCH == 1);
                drain_ptr <= '0;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              drain_ptr <= next_ptr;
              out_data  <= frame_buf[next_ptr];
              out_chan  <= next_ptr;
              out_last  <= (next_ptr == CH_W'(NCH - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Directed bench for cic_decim_mc (NCH=2, ORDER=3, RLOG2_MAX=6) with hand-derived CIC outputs.
module tb_cic_decim_mc;

  localparam int ACC_W = 19;
  localparam logic [ACC_W-1:0] POS4096 = 19'd4096;
  localparam logic [ACC_W-1:0] NEG4096 = 19'h7F000;
  localparam logic [ACC_W-1:0] WRAPPED = 19'h40000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [1:0]       in_bits;
  logic             cfg_load;
  logic [2:0]       cfg_rlog2;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [0:0]       out_chan;
  logic             out_last;
  logic             overrun;
  logic             settling;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0]       bits_const = 2'b11;
  bit               alt_mode   = 1'b0;
  bit               alt_phase  = 1'b0;
  logic [ACC_W-1:0] got_data[$];
  int               got_chan[$];
  int               got_last[$];
  int               lat;
  logic [ACC_W-1:0] held_data;

  cic_decim_mc #(.NCH(2), .ORDER(3), .RLOG2_MAX(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits),
    .cfg_load(cfg_load), .cfg_rlog2(cfg_rlog2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .out_last(out_last), .overrun(overrun), .settling(settling)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge: drive this cycle's bits, log a handshake due at the next posedge, advance.
  task automatic applyStimulus(input int ncycles);
    for (int i = 0; i < ncycles; i++) begin
      if (alt_mode) begin
        in_bits   = alt_phase ? 2'b11 : 2'b00;
        alt_phase = ~alt_phase;
      end else begin
        in_bits = bits_const;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_chan.push_back(int'(out_chan));
        got_last.push_back(int'(out_last));
      end
      @(negedge clk);
    end
  endtask

  task automatic waitValid(input string tag, input int max_cycles, output int n);
    n = 0;
    while (!out_valid && n < max_cycles) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, out_valid, 1);
  endtask

  task automatic loadConfig(input logic [2:0] r);
    got_data.delete();
    got_chan.delete();
    got_last.delete();
    cfg_load  = 1'b1;
    cfg_rlog2 = r;
    applyStimulus(1);
    cfg_load  = 1'b0;
  endtask

  task automatic checkWords(input string tag, input int n, input logic [ACC_W-1:0] exp0, input logic [ACC_W-1:0] exp1);
    checkOutput({tag, "_count"}, got_data.size() >= n, 1);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], (i % 2 == 0) ? exp0 : exp1);
      checkOutput($sformatf("%s_chan%0d", tag, i), got_chan[i], i % 2);
      checkOutput($sformatf("%s_last%0d", tag, i), got_last[i], i % 2);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_bits = 2'b00; cfg_load = 1'b0; cfg_rlog2 = 3'd0; out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_chan", out_chan, 0);
    checkOutput("rst_last", out_last, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_settling", settling, 1);

    $display("[TB] constant ones, R=16");
    bits_const = 2'b11;
    loadConfig(3'd4);
    checkOutput("flush_settling", settling, 1);
    applyStimulus(60);
    checkOutput("settle_before_f4", settling, 1);
    checkOutput("valid_before_f4", out_valid, 0);
    applyStimulus(10);
    checkOutput("settle_after_f4", settling, 0);
    applyStimulus(130);
    checkWords("ones", 6, POS4096, POS4096);
    checkOutput("ones_overrun", overrun, 0);

    $display("[TB] ch0 ones, ch1 zeros, R=16");
    bits_const = 2'b01;
    loadConfig(3'd4);
    applyStimulus(200);
    checkWords("mixed", 4, POS4096, NEG4096);

    $display("[TB] alternating pattern, R=16");
    alt_mode = 1'b1;
    loadConfig(3'd4);
    applyStimulus(200);
    checkWords("alt", 4, 19'd0, 19'd0);
    alt_mode = 1'b0;

    $display("[TB] backpressure, R=16");
    bits_const = 2'b11;
    out_ready  = 1'b0;
    loadConfig(3'd4);
    waitValid("bp_valid", 200, lat);
    checkOutput("bp_latency", lat, 65);
    held_data = out_data;
    applyStimulus(40);
    checkOutput("bp_hold_data", out_data, held_data);
    checkOutput("bp_hold_value", out_data, POS4096);
    checkOutput("bp_hold_chan", out_chan, 0);
    checkOutput("bp_overrun", overrun, 1);
    out_ready = 1'b1;
    applyStimulus(60);
    checkWords("bp_resume", 4, POS4096, POS4096);

    $display("[TB] cfg_load mid-drain, R=64");
    out_ready = 1'b0;
    loadConfig(3'd6);
    waitValid("r64_valid", 400, lat);
    applyStimulus(150);
    checkOutput("r64_overrun", overrun, 1);
    loadConfig(3'd6);
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_settling", settling, 1);
    checkOutput("abort_overrun", overrun, 0);
    out_ready = 1'b1;
    applyStimulus(300);
    checkWords("wrap", 2, WRAPPED, WRAPPED);

    $display("[TB] reset mid-frame");
    loadConfig(3'd4);
    applyStimulus(90);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst2_valid", out_valid, 0);
    checkOutput("rst2_data", out_data, 0);
    checkOutput("rst2_last", out_last, 0);
    checkOutput("rst2_settling", settling, 1);
    got_data.delete();
    got_chan.delete();
    got_last.delete();
    waitValid("rst2_wait", 400, lat);
    checkOutput("rst2_latency", lat, 257);
    applyStimulus(3);
    checkWords("rst2_word", 2, WRAPPED, WRAPPED);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
